// File: rtl/sprite_pkg.sv
// sprite_pkg: select/tile encodings and the tile-to-select mapping shared by the sprite select pipeline.
package sprite_pkg;
    typedef logic [3:0] sel_t;
    typedef logic [2:0] tile_t;

    localparam sel_t SEL_SPACE  = 4'd0;
    localparam sel_t SEL_POINT  = 4'd1;
    localparam sel_t SEL_POWER  = 4'd2;
    localparam sel_t SEL_FRUIT  = 4'd3;
    localparam sel_t SEL_EDIBLE = 4'd4;
    localparam sel_t SEL_PACMAN = 4'd5;
    localparam sel_t SEL_GATE   = 4'd6;
    localparam sel_t SEL_GHOST  = 4'd7;
    localparam sel_t SEL_WALL   = 4'd8;

    localparam tile_t TILE_SPACE = 3'd0;
    localparam tile_t TILE_POINT = 3'd1;
    localparam tile_t TILE_POWER = 3'd2;
    localparam tile_t TILE_FRUIT = 3'd3;
    localparam tile_t TILE_WALL  = 3'd4;
    localparam tile_t TILE_GATE  = 3'd5;

    function automatic sel_t tile_to_sel(input tile_t t);
        return t == TILE_POINT ? SEL_POINT :
               t == TILE_POWER ? SEL_POWER :
               t == TILE_FRUIT ? SEL_FRUIT :
               t == TILE_WALL  ? SEL_WALL  :
               t == TILE_GATE  ? SEL_GATE  : SEL_SPACE;
    endfunction
endpackage

// File: rtl/sprite_hit_detect.sv
// sprite_hit_detect: combinational test of one pixel against one actor box, with in-sprite offsets.
module sprite_hit_detect
    import sprite_pkg::*;
#(
    parameter int SPRITE_SIZE = 16
) (
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    output logic       hit,
    output logic [3:0] dx,
    output logic [3:0] dy
);
    logic [10:0] sx, sy;

    // Bit 10 is the borrow: a pixel left of/above the actor never wraps into a hit.
    assign sx  = {1'b0, draw_x} - {1'b0, pos_x};
    assign sy  = {1'b0, draw_y} - {1'b0, pos_y};
    assign hit = !sx[10] && !sy[10] && sx < 11'(SPRITE_SIZE) && sy < 11'(SPRITE_SIZE);
    assign dx  = sx[3:0];
    assign dy  = sy[3:0];
endmodule

// File: rtl/sprite_select_gen.sv
// sprite_select_gen: 2-stage per-pixel sprite class select from map tiles, shadowed actors and pellet blink.
// Optional SPRITE_FRIGHT_BLINK_EN adds fright_ending to flash frightened ghosts.
module sprite_select_gen
    import sprite_pkg::*;
#(
    parameter int TILE_SHIFT   = 4,
    parameter int MAP_COLS     = 40,
    parameter int MAP_ROWS     = 30,
    parameter int SPRITE_SIZE  = 16,
    parameter int NUM_GHOSTS   = 4,
    parameter int BLINK_FRAMES = 15
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic                    pixel_valid,
    input  logic                    frame_start,
    input  logic [9:0]              pac_x,
    input  logic [9:0]              pac_y,
    input  logic [10*NUM_GHOSTS-1:0] ghost_x,
    input  logic [10*NUM_GHOSTS-1:0] ghost_y,
    input  logic [NUM_GHOSTS-1:0]   ghost_fright,
`ifdef SPRITE_FRIGHT_BLINK_EN
    input  logic                    fright_ending,
`endif
    output logic [10:0]             map_addr,
    input  logic [2:0]              map_data,
    output logic [3:0]              select,
    output logic [3:0]              sprite_row,
    output logic [3:0]              sprite_col,
    output logic [1:0]              ghost_idx,
    output logic                    sel_valid
);
    localparam int CW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [9:0] pac_x_q, pac_y_q;
    logic [10*NUM_GHOSTS-1:0] gx_q, gy_q;
    logic [NUM_GHOSTS-1:0] fr_q;
    logic [CW-1:0] cnt_q;
    logic blink_on_q;

    logic [9:0] row, col;
    logic p_hit, g_any, g_fr;
    logic [3:0] p_dx, p_dy, g_dx, g_dy;
    logic [1:0] g_sel;
    logic [NUM_GHOSTS-1:0] g_hit;
    logic [3:0] gdx [NUM_GHOSTS];
    logic [3:0] gdy [NUM_GHOSTS];

    logic s1_pac_q, s1_ghost_q, s1_gfr_q, s1_off_q, s1_v_q;
    logic [1:0] s1_gidx_q;
    logic [3:0] s1_arow_q, s1_acol_q, s1_trow_q, s1_tcol_q;

    sel_t fright_sel, tile_sel, sel_d;
    logic [3:0] row_d, col_d;
    logic [1:0] gidx_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pac_x_q    <= '0;
            pac_y_q    <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            fr_q       <= '0;
            cnt_q      <= '0;
            blink_on_q <= 1'b1;
        end else if (frame_start) begin
            pac_x_q    <= pac_x;
            pac_y_q    <= pac_y;
            gx_q       <= ghost_x;
            gy_q       <= ghost_y;
            fr_q       <= ghost_fright;
            cnt_q      <= cnt_q == CW'(BLINK_FRAMES - 1) ? '0 : cnt_q + 1'b1;
            blink_on_q <= cnt_q == CW'(BLINK_FRAMES - 1) ? !blink_on_q : blink_on_q;
        end
    end

`ifdef SPRITE_FRIGHT_BLINK_EN
    logic fe_q;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) fe_q <= 1'b0;
        else if (frame_start) fe_q <= fright_ending;
    end
    assign fright_sel = (fe_q && !blink_on_q) ? SEL_GHOST : SEL_EDIBLE;
`else
    assign fright_sel = SEL_EDIBLE;
`endif

    assign row      = DrawY >> TILE_SHIFT;
    assign col      = DrawX >> TILE_SHIFT;
    assign map_addr = Reset ? '0 : 11'(row * MAP_COLS + col);

    sprite_hit_detect #(.SPRITE_SIZE(SPRITE_SIZE)) u_pac (
        .draw_x(DrawX), .draw_y(DrawY), .pos_x(pac_x_q), .pos_y(pac_y_q),
        .hit(p_hit), .dx(p_dx), .dy(p_dy)
    );

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_ghost
        sprite_hit_detect #(.SPRITE_SIZE(SPRITE_SIZE)) u_ghost (
            .draw_x(DrawX), .draw_y(DrawY), .pos_x(gx_q[10*g +: 10]), .pos_y(gy_q[10*g +: 10]),
            .hit(g_hit[g]), .dx(gdx[g]), .dy(gdy[g])
        );
    end

    // Scan from the top so the lowest-index hit is the one left standing.
    always_comb begin
        g_any = 1'b0;
        g_sel = '0;
        g_fr  = 1'b0;
        g_dx  = '0;
        g_dy  = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (g_hit[i]) begin
                g_any = 1'b1;
                g_sel = 2'(i);
                g_fr  = fr_q[i];
                g_dx  = gdx[i];
                g_dy  = gdy[i];
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            {s1_pac_q, s1_ghost_q, s1_gfr_q, s1_off_q, s1_v_q} <= '0;
            s1_gidx_q <= '0;
            {s1_arow_q, s1_acol_q, s1_trow_q, s1_tcol_q} <= '0;
        end else begin
            s1_pac_q   <= p_hit;
            s1_ghost_q <= g_any;
            s1_gfr_q   <= g_fr;
            s1_gidx_q  <= g_sel;
            s1_arow_q  <= p_hit ? p_dy : g_dy;
            s1_acol_q  <= p_hit ? p_dx : g_dx;
            s1_trow_q  <= 4'(DrawY & 10'((1 << TILE_SHIFT) - 1));
            s1_tcol_q  <= 4'(DrawX & 10'((1 << TILE_SHIFT) - 1));
            s1_off_q   <= col >= 10'(MAP_COLS) || row >= 10'(MAP_ROWS);
            s1_v_q     <= pixel_valid;
        end
    end

    always_comb begin
        tile_sel = (map_data == TILE_POWER && !blink_on_q) ? SEL_SPACE : tile_to_sel(map_data);
        sel_d    = !s1_v_q    ? SEL_SPACE :
                   s1_pac_q   ? SEL_PACMAN :
                   s1_ghost_q ? (s1_gfr_q ? fright_sel : SEL_GHOST) :
                   s1_off_q   ? SEL_SPACE : tile_sel;
        row_d    = !s1_v_q ? '0 : (s1_pac_q || s1_ghost_q) ? s1_arow_q : s1_trow_q;
        col_d    = !s1_v_q ? '0 : (s1_pac_q || s1_ghost_q) ? s1_acol_q : s1_tcol_q;
        gidx_d   = (s1_v_q && !s1_pac_q && s1_ghost_q) ? s1_gidx_q : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            select     <= '0;
            sprite_row <= '0;
            sprite_col <= '0;
            ghost_idx  <= '0;
            sel_valid  <= 1'b0;
        end else begin
            select     <= sel_d;
            sprite_row <= row_d;
            sprite_col <= col_d;
            ghost_idx  <= gidx_d;
            sel_valid  <= s1_v_q;
        end
    end
endmodule

// File: doc/sprite_select_gen.md
Name: sprite_select_gen

Overview:
- Upstream stage of the sprite picker. For every VGA pixel it produces the 4-bit sprite-class select, plus the sprite-local row/column that addresses the sprite ROMs feeding the picker's data inputs.
- Combines three sources: maze tile contents read from an external 1-cycle-latency map RAM, actor positions (Pac-Man and ghosts) shadowed once per frame, and a frame-counted power-pellet blink.
- Streaming, non-stalling pipeline with 2-cycle latency.

Parameters:
- TILE_SHIFT, 4, log2 of tile size in pixels (16x16 tiles).
- MAP_COLS, 40, tiles per map row.
- MAP_ROWS, 30, tile rows in the map.
- SPRITE_SIZE, 16, actor sprite width/height in pixels (power of 2, ≤16).
- NUM_GHOSTS, 4, number of ghost actors (1..4).
- BLINK_FRAMES, 15, frames per power-pellet blink half-period (≥1).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- pixel_valid  in  1  DrawX/DrawY is a visible pixel.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pac_x, pac_y  in  10 each  Pac-Man top-left position.
- ghost_x, ghost_y  in  10*NUM_GHOSTS each  packed ghost positions; ghost i occupies bits [10i+9:10i].
- ghost_fright  in  NUM_GHOSTS  per-ghost frightened flag.
- map_addr  out  11  map RAM read address, row*MAP_COLS+col.
- map_data  in  3  tile code returned one cycle after map_addr.
- select  out  4  sprite class to the picker.
- sprite_row, sprite_col  out  4 each  pixel offset inside the selected sprite or tile.
- ghost_idx  out  2  index of the ghost hit (0 when not a ghost).
- sel_valid  out  1  select/offsets correspond to a visible pixel.

Behaviour:
- Select encoding: 0 space, 1 point, 2 powerball, 3 fruit, 4 edible ghost, 5 Pac-Man, 6 ghost gate, 7 ghost, 8 wall. Values 9–15 are never driven.
- Tile codes from map_data: 0 space, 1 point, 2 powerball, 3 fruit, 4 wall, 5 gate. Codes 6 and 7 map to space.
- Reset values: all outputs 0, shadow positions 0, frightened shadow 0, blink counter 0, blink_on 1. map_addr resets to 0.
- Shadowing:
  - On frame_start, pac/ghost positions and ghost_fright are copied into shadow registers.
  - Only the shadows are used for hit tests, so mid-frame input changes are never visible.
  - The new values apply to pixels entering stage 0 the cycle after the pulse.
- Stage 0 (cycle N):
  - map_addr = (DrawY>>TILE_SHIFT)*MAP_COLS + (DrawX>>TILE_SHIFT).
  - Hit tests use an 11-bit subtract d = Draw − pos. A hit requires 0 ≤ dx < SPRITE_SIZE and 0 ≤ dy < SPRITE_SIZE; a negative d is a miss, so there is no wraparound at the screen edges.
  - Hit flags, offsets, the off-map flag (col ≥ MAP_COLS or row ≥ MAP_ROWS) and pixel_valid are registered.
- Stage 1 (cycle N+1): map_data arrives and priority is resolved.
  - Priority: Pac-Man (5) > lowest-index ghost hit (4 if its frightened shadow is set, else 7) > tile.
  - Powerball resolves to space (0) while blink_on = 0.
  - Off-map pixels resolve to space.
  - Results are registered onto the outputs at cycle N+2.
- Offsets:
  - For an actor hit: sprite_row/col = dy/dx of that actor.
  - Otherwise: the low TILE_SHIFT bits of DrawY/DrawX.
- Invalid pixels: if pixel_valid = 0, the result is forced to select 0, offsets 0, ghost_idx 0 and sel_valid 0; the pipeline still advances.
- Blink counter:
  - Increments on each frame_start.
  - When the counter reaches BLINK_FRAMES−1 and frame_start arrives, it clears to 0 and blink_on toggles.
- Simultaneous events: frame_start together with pixel_valid needs no special handling; the pixel uses the old shadows.
- Reset asserted mid-frame: everything clears immediately. sel_valid stays 0 until 2 cycles after the first valid pixel following reset release.

Optional Feature:
- Macro SPRITE_FRIGHT_BLINK_EN.
- When defined:
  - Extra input fright_ending (1 bit) is shadowed on frame_start.
  - When the shadowed value is 1, frightened ghosts alternate between select 4 and 7, using the same blink_on phase: 4 when blink_on = 1, 7 when 0.
- When undefined: the port is absent and frightened ghosts always give select 4.

Decomposition:
- Package sprite_pkg holds:
  - the select constants SEL_SPACE … SEL_WALL as 4-bit localparams;
  - the tile-code constants TILE_SPACE … TILE_GATE;
  - typedefs sel_t (logic [3:0]) and tile_t (logic [2:0]).
- One sub-module, sprite_hit_detect, is instantiated 1+NUM_GHOSTS times.
  - Combinational: takes Draw X/Y, position and SPRITE_SIZE; produces hit and dx/dy.

Test Plan:
- Reset release, then a valid pixel at (0,0) with map_data=4 returned the next cycle → select=8 and sel_valid=1 at cycle N+2; select/sel_valid are 0 before that.
- pac=(100,50), ghost0=(100,50), fright=0 → pixel (107,53): select=5, sprite_row=3, sprite_col=7. Pixel (116,50): no actor hit (dx=16), select comes from the tile.
- Ghost1 at (200,200) with fright[1]=1, ghost0 elsewhere → pixel (200,200): select=4, ghost_idx=1. Clear fright[1] mid-frame → select stays 4 until after the next frame_start, then 7.
- Tile code 2 with BLINK_FRAMES=2 → select=2 for 2 frames, 0 for 2 frames, 2 again.
- Pixel (650,10) or map_data=6 → select=0; pixel_valid=0 at any tile → select=0 and sel_valid=0.
- Pac=(5,5), pixel (2,2) → no wrap hit, tile result returned; Reset pulsed mid-line → outputs 0 at once and recover after 2 cycles.
